// File: rtl/vrp_pkg.sv
// Shared constants and width helpers for the valid/ready FIFO slice.
package vrp_pkg;

    localparam int VRP_DEF_PLD_WIDTH = 32;

    // Address width that never collapses to zero bits for tiny depths.
    function automatic int vrp_addr_w(input int depth);
        int w;
        w = $clog2(depth);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/vrp_fifo_mem.sv
// DEPTH x PLD_WIDTH register file: one synchronous write port, one asynchronous read port.
module vrp_fifo_mem
    import vrp_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PLD_WIDTH = VRP_DEF_PLD_WIDTH,
    parameter int ADDR_W    = vrp_addr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [PLD_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [PLD_WIDTH-1:0] rdata
);

    logic [PLD_WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/vrp_fifo.sv
// Valid/ready FIFO with registered first-word-fall-through head, occupancy and almost-full.
module vrp_fifo
    import vrp_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PLD_WIDTH = VRP_DEF_PLD_WIDTH,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 vld_s,
    output logic                 rdy_s,
    input  logic [PLD_WIDTH-1:0] pld_s,
    output logic                 vld_m,
    input  logic                 rdy_m,
    output logic [PLD_WIDTH-1:0] pld_m,
    output logic [CNT_W-1:0]     cnt,
    output logic                 afull
);

    localparam int PTR_W = vrp_addr_w(DEPTH);

    typedef logic [CNT_W-1:0] vrp_cnt_t;
    typedef logic [PTR_W-1:0] vrp_ptr_t;

    localparam vrp_cnt_t CNT_ZERO  = vrp_cnt_t'(0);
    localparam vrp_cnt_t CNT_ONE   = vrp_cnt_t'(1);
    localparam vrp_cnt_t CNT_FULL  = vrp_cnt_t'(DEPTH);
    localparam vrp_cnt_t CNT_AFULL = vrp_cnt_t'(AFULL_TH);
    localparam vrp_ptr_t PTR_ZERO  = vrp_ptr_t'(0);
    localparam vrp_ptr_t PTR_ONE   = vrp_ptr_t'(1);

    vrp_ptr_t wr_ptr_r;
    vrp_ptr_t rd_ptr_r;
    vrp_cnt_t cnt_r;
    vrp_ptr_t wr_ptr_nxt_s;
    vrp_ptr_t rd_ptr_nxt_s;
    vrp_cnt_t cnt_nxt_s;
    logic     push_s;
    logic     pop_s;
    logic     we_s;

    // Handshakes only see registered state, so rdy_m never reaches rdy_s.
    assign rdy_s  = (cnt_r != CNT_FULL);
    assign vld_m  = (cnt_r != CNT_ZERO);
    assign cnt    = cnt_r;
    assign afull  = (cnt_r >= CNT_AFULL);
    assign push_s = vld_s & rdy_s;
    assign pop_s  = vld_m & rdy_m;
    assign we_s   = push_s & ~clr;

    // Next pointer/occupancy; a flush outranks any push or pop in the same cycle.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        cnt_nxt_s    = cnt_r;
        if (clr) begin
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            cnt_nxt_s    = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
                2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
                default: cnt_nxt_s = cnt_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    vrp_fifo_mem #(
        .DEPTH     (DEPTH),
        .PLD_WIDTH (PLD_WIDTH),
        .ADDR_W    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (pld_s),
        .raddr (rd_ptr_r),
        .rdata (pld_m)
    );

endmodule

// File: tb/tb_vrp_fifo.sv
// Scoreboard bench for vrp_fifo (DEPTH=4, AFULL_TH=3): queue model checked every cycle.
module tb_vrp_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        vld_s = 1'b0;
    logic        rdy_s;
    logic [31:0] pld_s = 32'd0;
    logic        vld_m;
    logic        rdy_m = 1'b0;
    logic [31:0] pld_m;
    logic [2:0]  cnt;
    logic        afull;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int max_cnt  = 0;
    logic [31:0] sb_q[$];

    vrp_fifo dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .vld_s (vld_s),
        .rdy_s (rdy_s),
        .pld_s (pld_s),
        .vld_m (vld_m),
        .rdy_m (rdy_m),
        .pld_m (pld_m),
        .cnt   (cnt),
        .afull (afull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Mid-cycle monitor: compare flags to the model, then apply the coming edge's transfers.
    always @(negedge clk) begin
        chk("mon_cnt", 32'(cnt), 32'(sb_q.size()));
        chk("mon_vld_m", 32'(vld_m), 32'(sb_q.size() != 0));
        chk("mon_rdy_s", 32'(rdy_s), 32'(sb_q.size() != 4));
        chk("mon_afull", 32'(afull), 32'(sb_q.size() >= 3));
        if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        if (rst || clr) begin
            sb_q.delete();
        end else begin
            if (vld_m && rdy_m) begin
                if (sb_q.size() == 0) begin
                    chk("pop_on_empty", 32'd1, 32'd0);
                end else begin
                    chk("pld_m", pld_m, sb_q.pop_front());
                end
                rx_cnt++;
            end
            if (vld_s && rdy_s) sb_q.push_back(pld_s);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        vld_s = 1'b1;
        pld_s = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy_s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        cycle();
        vld_s = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        rdy_m = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (cnt == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        rdy_m = 1'b0;
        cycle();
    endtask

    initial begin
        int rx0;
        bit ok;
        bit acc;

        // Reset then idle
        repeat (3) cycle();
        chk("rst_vld_m", 32'(vld_m), 32'd0);
        chk("rst_rdy_s", 32'(rdy_s), 32'd1);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        rst = 1'b0;
        repeat (3) cycle();
        chk("idle_vld_m", 32'(vld_m), 32'd0);
        chk("idle_rdy_s", 32'(rdy_s), 32'd1);

        // Fill with rdy_m=0, hold off a fifth word, then drain
        for (int i = 0; i < 4; i++) begin
            push_word(32'hA0 + 32'(i));
            chk("fill_cnt", 32'(cnt), 32'(i + 1));
            chk("fill_afull", 32'(afull), 32'(i >= 2));
        end
        chk("full_rdy_s", 32'(rdy_s), 32'd0);
        chk("full_head", pld_m, 32'hA0);
        vld_s = 1'b1;
        pld_s = 32'hA4;
        repeat (2) cycle();
        chk("held_cnt", 32'(cnt), 32'd4);
        rdy_m = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy_s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("a4_timeout", 32'd0, 32'd1);
        cycle();
        vld_s = 1'b0;
        drain();

        // Streaming, 100 words, no bubbles
        rx0 = rx_cnt;
        rdy_m = 1'b1;
        vld_s = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pld_s = 32'(i);
            cycle();
            if (i == 0) chk("stream_first_vld", 32'(vld_m), 32'd1);
            chk("stream_cnt", 32'(cnt), 32'd1);
        end
        vld_s = 1'b0;
        repeat (2) cycle();
        chk("stream_rx", 32'(rx_cnt - rx0), 32'd100);
        rdy_m = 1'b0;

        // Full with simultaneous pop: no ready that cycle
        for (int i = 0; i < 4; i++) push_word(32'hB0 + 32'(i));
        rdy_m = 1'b1;
        vld_s = 1'b1;
        pld_s = 32'hB4;
        @(negedge clk);
        chk("fullpop_rdy_s", 32'(rdy_s), 32'd0);
        cycle();
        chk("fullpop_cnt3", 32'(cnt), 32'd3);
        rdy_m = 1'b0;
        cycle();
        chk("fullpop_cnt4", 32'(cnt), 32'd4);
        vld_s = 1'b0;
        drain();

        // Random push/pop with pointer wrap
        max_cnt = 0;
        acc = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (acc || !vld_s) begin
                vld_s = 1'($urandom_range(0, 1));
                pld_s = $urandom;
            end
            rdy_m = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = vld_s && rdy_s;
            cycle();
        end
        vld_s = 1'b0;
        drain();
        chk("wrap_max_cnt", 32'(max_cnt <= 4), 32'd1);

        // clr with cnt=3 and a push in the same cycle
        for (int i = 0; i < 3; i++) push_word(32'hC0 + 32'(i));
        vld_s = 1'b1;
        pld_s = 32'hC3;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        vld_s = 1'b0;
        chk("clr_cnt", 32'(cnt), 32'd0);
        chk("clr_vld_m", 32'(vld_m), 32'd0);
        rdy_m = 1'b1;
        repeat (3) cycle();
        rdy_m = 1'b0;
        push_word(32'hD0);
        chk("post_clr_head", pld_m, 32'hD0);
        drain();

        // Async reset mid-operation with cnt=2
        push_word(32'hE0);
        push_word(32'hE1);
        chk("pre_rst_cnt", 32'(cnt), 32'd2);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("async_vld_m", 32'(vld_m), 32'd0);
        chk("async_cnt", 32'(cnt), 32'd0);
        cycle();
        #2;
        rst = 1'b0;
        cycle();
        chk("post_rst_vld_m", 32'(vld_m), 32'd0);
        chk("post_rst_rdy_s", 32'(rdy_s), 32'd1);
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
